// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM-style pipeline boundaries.
//  - CTRL_* : bit positions inside the control enable field
//  - pipe_state_t : occupancy state of a pipeline boundary register
package arm_pipe_pkg;

    localparam int CTRL_WB = 0;   // write-back enable
    localparam int CTRL_MR = 1;   // memory read enable
    localparam int CTRL_MW = 2;   // memory write enable

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HEAD  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/exe_mem_pipe_stage_if.sv
// EXE->MEM boundary bus: upstream valid/ready with instruction payload,
// downstream valid/ready with the head entry.
//  master : the surrounding pipeline (drives in_*, out_ready)
//  slave  : the boundary stage (drives in_ready, out_*)
interface exe_mem_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CTRL_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_alu_res;
    logic [DATA_W-1:0] in_val_rm;
    logic [DEST_W-1:0] in_dest;

    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_alu_res;
    logic [DATA_W-1:0] out_val_rm;
    logic [DEST_W-1:0] out_dest;

    modport master (
        output in_valid, in_ctrl, in_alu_res, in_val_rm, in_dest, out_ready,
        input  in_ready, out_valid, out_ctrl, out_alu_res, out_val_rm, out_dest
    );

    modport slave (
        input  in_valid, in_ctrl, in_alu_res, in_val_rm, in_dest, out_ready,
        output in_ready, out_valid, out_ctrl, out_alu_res, out_val_rm, out_dest
    );
endinterface

// File: rtl/pipe_entry.sv
// One storage slot of the boundary: valid + ctrl + payload.
//  clk, rst  : clock, async active-high reset (everything to 0)
//  ld        : capture d_* and mark valid
//  clr       : drop the entry (valid and ctrl to 0); dominates ld
//  d_*       : entry to load
//  q_*       : stored entry
// Payload is left untouched on clr so an invalid slot never toggles data.
module pipe_entry #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_alu_res,
    input  logic [DATA_W-1:0] d_val_rm,
    input  logic [DEST_W-1:0] d_dest,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_alu_res,
    output logic [DATA_W-1:0] q_val_rm,
    output logic [DEST_W-1:0] q_dest
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid   <= 1'b0;
            q_ctrl    <= '0;
            q_alu_res <= '0;
            q_val_rm  <= '0;
            q_dest    <= '0;
        end else if (clr) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
        end else if (ld) begin
            q_valid   <= 1'b1;
            q_ctrl    <= d_ctrl;
            q_alu_res <= d_alu_res;
            q_val_rm  <= d_val_rm;
            q_dest    <= d_dest;
        end
    end
endmodule

// File: rtl/exe_mem_pipe_stage.sv
// EXE->MEM pipeline boundary with valid/ready flow control.
//  clk, rst  : clock, async active-high reset
//  flush     : synchronous drop of every held entry and of any incoming one
//  bus       : slave side of the EXE->MEM bus (in_* from EXE, out_* to MEM)
//  stall_cnt : saturating count of cycles with out_valid & !out_ready
// SKID=1 keeps a second slot so in_ready comes straight from the state flops;
// SKID=0 is a single slot whose in_ready looks through to out_ready.
// An empty stage presents ctrl=0, so MEM sees a harmless bubble.
module exe_mem_pipe_stage
    import arm_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CTRL_W = 3,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    exe_mem_pipe_stage_if.slave  bus,
    output logic [CNT_W-1:0]     stall_cnt
);
    pipe_state_t state;
    logic push, pop;
    logic head_ld, head_clr, skid_ld, skid_clr;

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_alu_res, skid_val_rm;
    logic [DEST_W-1:0] skid_dest;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Slot enables. The head only ever loads from the skid slot when the skid
    // holds something (FULL + pop); otherwise it loads from EXE.
    always_comb begin
        head_ld  = 1'b0;
        head_clr = 1'b0;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (flush) begin
            head_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: head_ld = push;
                ST_HEAD: begin
                    skid_ld  = push & ~pop;
                    head_ld  = push & pop;
                    head_clr = pop & ~push;
                end
                ST_FULL: begin
                    head_ld  = pop;
                    skid_clr = pop;
                end
                default: ;
            endcase
        end
    end

    // With SKID=0 the HEAD push&!pop arc is unreachable (in_ready is low),
    // so the same state machine serves both variants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (push) state <= ST_HEAD;
                ST_HEAD: begin
                    if (push && !pop)      state <= ST_FULL;
                    else if (pop && !push) state <= ST_EMPTY;
                end
                ST_FULL:  if (pop) state <= ST_HEAD;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    pipe_entry #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W)) u_head (
        .clk       (clk),
        .rst       (rst),
        .ld        (head_ld),
        .clr       (head_clr),
        .d_ctrl    (skid_valid ? skid_ctrl    : bus.in_ctrl),
        .d_alu_res (skid_valid ? skid_alu_res : bus.in_alu_res),
        .d_val_rm  (skid_valid ? skid_val_rm  : bus.in_val_rm),
        .d_dest    (skid_valid ? skid_dest    : bus.in_dest),
        .q_valid   (bus.out_valid),
        .q_ctrl    (bus.out_ctrl),
        .q_alu_res (bus.out_alu_res),
        .q_val_rm  (bus.out_val_rm),
        .q_dest    (bus.out_dest)
    );

    generate
        if (SKID != 0) begin : g_skid
            assign bus.in_ready = (state != ST_FULL);
            pipe_entry #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W)) u_skid (
                .clk       (clk),
                .rst       (rst),
                .ld        (skid_ld),
                .clr       (skid_clr),
                .d_ctrl    (bus.in_ctrl),
                .d_alu_res (bus.in_alu_res),
                .d_val_rm  (bus.in_val_rm),
                .d_dest    (bus.in_dest),
                .q_valid   (skid_valid),
                .q_ctrl    (skid_ctrl),
                .q_alu_res (skid_alu_res),
                .q_val_rm  (skid_val_rm),
                .q_dest    (skid_dest)
            );
        end else begin : g_single
            assign bus.in_ready  = ~bus.out_valid | bus.out_ready;
            assign skid_valid    = 1'b0;
            assign skid_ctrl     = '0;
            assign skid_alu_res  = '0;
            assign skid_val_rm   = '0;
            assign skid_dest     = '0;
        end
    endgenerate

    // Counts stalls in flush cycles too; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (bus.out_valid && !bus.out_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
